sipo_deserializer: RTL and testbench
====================================

# sipo_deserializer

- Serial-in, parallel-out deserializer; the stage directly downstream of the parallel-load serial-out shift register.
- Collects a framed, bit-strobed serial stream into WIDTH-bit words and presents them on a valid/ready output port.
- A one-word output buffer lets the next word shift in while the previous word is still waiting to be consumed.
- Reports mid-word resynchronisation and dropped words.

## Interface
- WIDTH, 4, word width in bits; legal range ≥ 1.
- MSB_FIRST, 1, 1: first received bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0].
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sin  in  1  serial data bit, sampled only when sin_valid=1.
- sin_valid  in  1  bit strobe, one bit per cycle when high.
- frame_start  in  1  marks the first bit of a word; qualified by sin_valid.
- dout  out  WIDTH  assembled word.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout when dout_valid=1 and dout_ready=1.
- overrun  out  1  one-cycle pulse: a completed word was dropped.
- frame_err  out  1  one-cycle pulse: a partial word was discarded by resync.

## Operation
- Internal state: shift register sh[WIDTH], bit counter cnt (range 0..WIDTH-1), FSM {IDLE, SHIFT}.
- An accepted bit is sin_valid=1 in a state that takes it. Bits are inserted at the LSB and shifted toward the MSB when MSB_FIRST=1, and mirrored when MSB_FIRST=0.

**IDLE**
- sin_valid=1 with frame_start=0: bit ignored.
- sin_valid=1 with frame_start=1: bit captured, cnt←1, go to SHIFT.
- frame_start with sin_valid=0 is ignored in every state.

**SHIFT**
- sin_valid=1 with frame_start=0: bit captured, cnt←cnt+1.
- sin_valid=1 with frame_start=1: partial word discarded, frame_err pulses, the bit starts a new word, cnt←1, stay in SHIFT.
- sin_valid=0: hold (gaps of any length are allowed).

**Word complete**
- A word completes on the accepted bit that makes WIDTH bits.
- FSM→IDLE and cnt←0. The next word requires a new frame_start.
- WIDTH=1: every frame_start bit completes a word immediately, and the FSM stays in IDLE.

**Output buffer**
- Load: on completion, if dout_valid=0, or dout_valid=1 and dout_ready=1 in the same cycle, then dout←assembled word and dout_valid←1.
- Drop: otherwise the new word is dropped, overrun pulses, and dout/dout_valid are unchanged.
- Consume: dout_valid=1 and dout_ready=1 with no completion in that cycle gives dout_valid←0. dout keeps its last value.
- dout_ready is ignored when dout_valid=0.

## Timing
- Reset values: dout=0, dout_valid=0, overrun=0, frame_err=0, FSM=IDLE, cnt=0, sh=0. Reset takes effect immediately on rst_n low, asynchronously.
- Reset asserted mid-word or with a word pending: all of it is lost, with no overrun or frame_err pulse.
- Latency: dout_valid rises at the clock edge that samples the last bit, i.e. visible in the cycle after the last bit is presented.
- Throughput: back-to-back words at one bit per cycle sustain with no gap, provided the consumer drains one word per WIDTH cycles.
- overrun and frame_err are registered and high for exactly one cycle per event.
- Both flags can assert in the same cycle only if the resync bit itself completes a word (WIDTH=1 never sets frame_err).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package sipo_pkg:
  - state enum {IDLE, SHIFT};
  - function for counter width, $clog2(WIDTH+1).
- Sub-module sipo_out_buf: the one-entry valid/ready holding register with load, drop and overrun logic. The top module keeps the FSM, counter and shift register.

## Test plan
- Basic word (WIDTH=4, MSB_FIRST=1): frame_start with bits 1,0,1,1 on consecutive cycles, dout_ready=1 → dout=4'hB with dout_valid for one cycle after the 4th bit; no flags.
- LSB-first (MSB_FIRST=0): same bits 1,0,1,1 → dout=4'hD.
- Gaps and orphan bits:
  - sin_valid=1 without frame_start in IDLE → ignored.
  - Bits 0,1 then 3 idle cycles then 1,0 → dout=4'h6, unaffected by the gaps.
- Resync: frame_start, bits 1,1, then frame_start with bits 0,0,1,1 → frame_err pulses once at the second frame_start; dout=4'h3.
- Backpressure and overrun: dout_ready=0, send 4'hA then 4'h5 back-to-back.
  - 4'hA held, the 4'h5 completion pulses overrun, dout stays 4'hA.
  - Repeat with dout_ready=1 exactly in the completion cycle → dout=4'h5 and no overrun.
- Reset mid-operation: rst_n low after 2 bits, and separately with dout_valid=1 → all outputs 0 immediately and no flags. The next framed 4'h9 is received correctly.

Source files
------------

// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_pkg
// Purpose  : Shared types and helpers for the serial-in, parallel-out
//            deserializer: the framing FSM state type and the bit-counter
//            width function.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package sipo_pkg;

  // Framing FSM: IDLE waits for a frame_start bit, SHIFT collects the rest.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_e;

  // Counter width sized so WIDTH itself is representable.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : sipo_out_buf
// Purpose  : One-entry valid/ready holding register for completed words.
//            A completed word loads when the entry is empty or is being
//            consumed in the same cycle; otherwise it is dropped and a
//            one-cycle overrun pulse is raised.
// Ports    : clk, rst_n        - clock, async active-low reset
//            word_done, word   - completion strobe and assembled word
//            dout_ready        - consumer accept
//            dout, dout_valid  - held word and its valid flag
//            overrun           - registered pulse, completed word dropped
// Revision : 1.0 - initial release
// ============================================================================
module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             word_done,
  input  logic [WIDTH-1:0] word,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             load;

  always_comb begin
    // A pending word being consumed this cycle frees the slot for the new one.
    load      = word_done & (~valid_q | dout_ready);
    overrun_d = word_done & valid_q & ~dout_ready;
    dout_d    = dout_q;
    valid_d   = valid_q;
    if (load) begin
      dout_d  = word;
      valid_d = 1'b1;
    end else if (valid_q && dout_ready) begin
      // dout keeps its last value after consumption.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = overrun_q;

endmodule : sipo_out_buf
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : sipo_deserializer
// Purpose  : Collects a framed, bit-strobed serial stream into WIDTH-bit
//            words and presents them through a one-word valid/ready buffer.
//            Flags mid-word resynchronisation and dropped words.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            sin, sin_valid, frame_start - serial bit, strobe, word start
//            dout, dout_valid, dout_ready- parallel output handshake
//            overrun                     - pulse, completed word dropped
//            frame_err                   - pulse, partial word discarded
// Revision : 1.0 - initial release
// ============================================================================
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
  localparam bit                SINGLE   = (WIDTH == 1);

  sipo_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sh_base;
  logic [WIDTH-1:0] sh_ins;
  logic             frame_err_q, frame_err_d;
  logic             accept;
  logic             word_done;

  // A frame_start bit begins from a clean register so no stale bits of an
  // abandoned word can leak into the new one.
  assign sh_base = frame_start ? '0 : sh_q;

  // Bit insertion: new bit enters at the LSB and moves toward the MSB for
  // MSB-first streams, and the mirror image for LSB-first streams.
  if (WIDTH == 1) begin : g_single
    assign sh_ins = sin;
  end else if (MSB_FIRST) begin : g_msb_first
    assign sh_ins = {sh_base[WIDTH-2:0], sin};
  end else begin : g_lsb_first
    assign sh_ins = {sin, sh_base[WIDTH-1:1]};
  end

  always_comb begin
    accept      = sin_valid & (frame_start | (state_q == SHIFT));
    frame_err_d = sin_valid & frame_start & (state_q == SHIFT);
    // A start bit completes a word only when the word is one bit wide.
    word_done   = accept & (frame_start ? SINGLE : (cnt_q == LAST_CNT));

    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    if (accept) begin
      sh_d = sh_ins;
      if (word_done) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (frame_start) begin
        state_d = SHIFT;
        cnt_d   = CNT_W'(1);
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

  // sh_ins is the fully assembled word in the cycle word_done is high.
  sipo_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_done  (word_done),
    .word       (sh_ins),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overrun    (overrun)
  );

endmodule : sipo_deserializer
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_deserializer
// Purpose  : Self-checking bench for sipo_deserializer. Two instances (MSB-
//            first and LSB-first, WIDTH=4) share one stimulus stream. A
//            queue-based model of the framing rules and output buffer
//            predicts every output; directed cases pin the model with
//            literal expectations, then randomized traffic runs.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         sin;
  logic         sin_valid;
  logic         frame_start;
  logic         dout_ready;
  logic [W-1:0] dout_m, dout_l;
  logic         valid_m, valid_l;
  logic         ovr_m, ovr_l;
  logic         ferr_m, ferr_l;

  int checks = 0;
  int errors = 0;

  // Model state: bits of the word in progress, and the output buffer.
  bit           q[$];
  logic [W-1:0] m_dm, m_dl;
  logic         m_valid, m_ovr, m_ferr;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
    .frame_start(frame_start), .dout(dout_m), .dout_valid(valid_m),
    .dout_ready(dout_ready), .overrun(ovr_m), .frame_err(ferr_m)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
    .frame_start(frame_start), .dout(dout_l), .dout_valid(valid_l),
    .dout_ready(dout_ready), .overrun(ovr_l), .frame_err(ferr_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dm = '0; m_dl = '0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the register values after the next
  // rising edge, then return 1 time unit after that edge.
  task automatic step(input logic sv, input logic fs, input logic s, input logic rdy);
    logic         n_ferr, n_ovr, n_valid, done;
    logic [W-1:0] wm, wl, n_dm, n_dl;
    sin_valid = sv; frame_start = fs; sin = s; dout_ready = rdy;
    n_ferr = 1'b0; n_ovr = 1'b0; done = 1'b0; wm = '0; wl = '0;
    if (sv) begin
      if (fs) begin
        if (q.size() != 0) n_ferr = 1'b1;
        q.delete();
        q.push_back(s);
      end else if (q.size() != 0) begin
        q.push_back(s);
      end
      if (q.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = q[i];
          wl[i]     = q[i];
        end
        done = 1'b1;
        q.delete();
      end
    end
    n_valid = m_valid; n_dm = m_dm; n_dl = m_dl;
    if (done) begin
      if (!m_valid || rdy) begin
        n_valid = 1'b1; n_dm = wm; n_dl = wl;
      end else begin
        n_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      n_valid = 1'b0;
    end
    @(posedge clk);
    m_dm = n_dm; m_dl = n_dl; m_valid = n_valid; m_ovr = n_ovr; m_ferr = n_ferr;
    #1;
  endtask

  // Send four framed bits seq[3] first; rdy_last applies to the final bit.
  task automatic word4(input logic [3:0] seq, input logic rdy_early, input logic rdy_last);
    for (int i = 3; i >= 0; i--)
      step(1'b1, (i == 3), seq[i], (i == 0) ? rdy_last : rdy_early);
  endtask

  task automatic do_reset();
    sin_valid = 1'b0; frame_start = 1'b0; sin = 1'b0; dout_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_dout",  dout_m,  0);
    chk("rst_async_valid", valid_m, 0);
    chk("rst_async_ovr",   ovr_m,   0);
    chk("rst_async_ferr",  ferr_m,  0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Every falling edge: both instances against the model.
  always @(negedge clk) begin
    chk("cmp_dout_msb",  dout_m,  m_dm);
    chk("cmp_dout_lsb",  dout_l,  m_dl);
    chk("cmp_valid_msb", valid_m, m_valid);
    chk("cmp_valid_lsb", valid_l, m_valid);
    chk("cmp_ovr_msb",   ovr_m,   m_ovr);
    chk("cmp_ovr_lsb",   ovr_l,   m_ovr);
    chk("cmp_ferr_msb",  ferr_m,  m_ferr);
    chk("cmp_ferr_lsb",  ferr_l,  m_ferr);
  end

  initial begin
    rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; frame_start = 1'b0; dout_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("reset_dout",  dout_m,  0);
    chk("reset_valid", valid_m, 0);
    chk("reset_ovr",   ovr_m,   0);
    chk("reset_ferr",  ferr_m,  0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Basic word 1,0,1,1.
    word4(4'b1011, 1'b1, 1'b1);
    chk("basic_valid", valid_m, 1);
    chk("basic_msb",   dout_m,  4'hB);
    chk("basic_lsb",   dout_l,  4'hD);
    chk("model_basic_msb", m_dm, 4'hB);
    chk("model_basic_lsb", m_dl, 4'hD);
    chk("basic_flags", {ovr_m, ferr_m}, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic_consumed", valid_m, 0);
    chk("basic_dout_kept", dout_m, 4'hB);

    // Orphan bits in IDLE are ignored.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("orphan_valid", valid_m, 0);

    // Gaps: 0,1, idle (including a strobeless frame_start), then 1,0.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("gap_valid", valid_m, 1);
    chk("gap_msb",   dout_m,  4'h6);
    chk("gap_lsb",   dout_l,  4'h6);
    chk("model_gap", m_dm,    4'h6);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Resync: 1,1 then a new frame 0,0,1,1.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("resync_ferr",   ferr_m, 1);
    chk("model_resync_ferr", m_ferr, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("resync_ferr_pulse", ferr_m, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("resync_msb", dout_m, 4'h3);
    chk("resync_lsb", dout_l, 4'hC);
    chk("model_resync_lsb", m_dl, 4'hC);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: A held, 5 dropped.
    word4(4'hA, 1'b0, 1'b0);
    chk("bp_first_valid", valid_m, 1);
    chk("bp_first_msb",   dout_m,  4'hA);
    word4(4'h5, 1'b0, 1'b0);
    chk("bp_overrun",     ovr_m,   1);
    chk("model_overrun",  m_ovr,   1);
    chk("bp_held_msb",    dout_m,  4'hA);
    chk("bp_held_lsb",    dout_l,  4'h5);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_overrun_pulse", ovr_m, 0);
    chk("bp_still_valid",   valid_m, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Ready exactly in the completion cycle replaces the held word.
    word4(4'hA, 1'b0, 1'b0);
    word4(4'h5, 1'b0, 1'b1);
    chk("swap_msb",   dout_m,  4'h5);
    chk("swap_lsb",   dout_l,  4'hA);
    chk("swap_novr",  ovr_m,   0);
    chk("swap_valid", valid_m, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word, then the stale tail bits must be ignored.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_mid_valid", valid_m, 0);

    // Reset with a pending word.
    word4(4'hF, 1'b0, 1'b0);
    chk("pending_valid", valid_m, 1);
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    word4(4'h9, 1'b1, 1'b1);
    chk("post_rst_msb",   dout_m, 4'h9);
    chk("post_rst_lsb",   dout_l, 4'h9);
    chk("post_rst_flags", {ovr_m, ferr_m}, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic, occasionally with a bursty ready-high phase.
    for (int n = 0; n < 3000; n++) begin
      logic sv, fs, s, rdy;
      sv  = ($urandom_range(0, 3) != 0);
      fs  = ($urandom_range(0, 5) == 0);
      s   = 1'($urandom);
      rdy = (n % 500 < 250) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      step(sv, fs, s, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sipo_deserializer
`default_nettype wire
